regfile_access_ctrl: RTL

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

---
 rtl/regfile_access_ctrl_pkg.sv | 25 ++
 rtl/regfile_sram.sv | 28 ++
 rtl/regfile_access_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// rtl/regfile_access_ctrl_pkg.sv - shared constants and state encoding for the register-file access controller
package regfile_access_ctrl_pkg;

  // Default geometry: 32 registers of 32 bits.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Register index that is hard-wired to zero: never written, always reads 0.
  localparam int ZERO_REG = 0;

  // Controller state encoding.
  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t ST_IDLE  = 3'd0;
  localparam ctrl_state_t ST_RD_RS = 3'd1;
  localparam ctrl_state_t ST_RD_RT = 3'd2;
  localparam ctrl_state_t ST_LAST  = 3'd3;
  localparam ctrl_state_t ST_RESP  = 3'd4;

  // The array port is free for a writeback in every state that issues no read.
  function automatic logic state_wb_open(input ctrl_state_t s);
    return (s == ST_IDLE) || (s == ST_LAST) || (s == ST_RESP);
  endfunction

endpackage

// File: rtl/regfile_sram.sv
// rtl/regfile_sram.sv - single-port register array with one-cycle synchronous read
module regfile_sram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read-first port: a read returns the stored word on the following cycle.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - two-operand read sequencer with writeback priority and bypass onto a single-port array
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs_data,
  output logic [DATA_W-1:0] rsp_rt_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_rs;
  logic [ADDR_W-1:0] r_rt;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;

  logic w_req_fire;
  logic w_rsp_fire;
  logic w_wb_fire;
  logic w_wb_nonzero;
  logic w_byp_window;
  logic w_byp_rs;
  logic w_byp_rt;
  logic w_rs_zero;
  logic w_rt_zero;

  assign w_req_fire   = req_valid && req_ready;
  assign w_rsp_fire   = rsp_valid && rsp_ready;
  assign w_wb_fire    = wb_valid && wb_ready;
  assign w_wb_nonzero = (wb_rd != ZERO_IDX);
  assign w_rs_zero    = (r_rs == ZERO_IDX);
  assign w_rt_zero    = (r_rt == ZERO_IDX);

  // A write landing after the operand reads were issued must overwrite the stale copy.
  assign w_byp_window = (r_state == ST_LAST) || (r_state == ST_RESP);
  assign w_byp_rs     = w_byp_window && w_wb_fire && w_wb_nonzero && (wb_rd == r_rs);
  assign w_byp_rt     = w_byp_window && w_wb_fire && w_wb_nonzero && (wb_rd == r_rt);

  // Writeback wins over a new request in IDLE; nothing is accepted while reset is held.
  assign req_ready = !rst && (r_state == ST_IDLE) && !wb_valid;
  assign wb_ready  = !rst && wb_valid && state_wb_open(r_state);
  assign rsp_valid = !rst && (r_state == ST_RESP);

  assign rsp_rs_data = r_rs_data;
  assign rsp_rt_data = r_rt_data;

  // Next-state: fixed four-cycle read walk, then hold in RESP until the consumer takes it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_fire) w_state_nxt = ST_RD_RS;
      ST_RD_RS: w_state_nxt = ST_RD_RT;
      ST_RD_RT: w_state_nxt = ST_LAST;
      ST_LAST:  w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_fire) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand indices are latched on request accept and held through the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs <= '0;
      r_rt <= '0;
    end else if (w_req_fire) begin
      r_rs <= req_rs;
      r_rt <= req_rt;
    end
  end

  // rs data: captured when its read returns, later overridden by a matching writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_data <= '0;
    end else if (r_state == ST_RD_RT) begin
      r_rs_data <= w_rs_zero ? '0 : mem_rdata;
    end else if (w_byp_rs) begin
      r_rs_data <= wb_data;
    end
  end

  // rt data: a writeback in LAST beats the in-flight read of the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rt_data <= '0;
    end else if (w_byp_rt) begin
      r_rt_data <= wb_data;
    end else if (r_state == ST_LAST) begin
      r_rt_data <= w_rt_zero ? '0 : mem_rdata;
    end
  end

  // Array port: reads in RD_RS/RD_RT, otherwise an accepted writeback; index 0 is never written.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (r_state)
        ST_RD_RS: begin
          mem_en   = 1'b1;
          mem_addr = r_rs;
        end
        ST_RD_RT: begin
          mem_en   = 1'b1;
          mem_addr = r_rt;
        end
        default: begin
          if (w_wb_fire) begin
            mem_en    = 1'b1;
            mem_we    = w_wb_nonzero;
            mem_addr  = wb_rd;
            mem_wdata = wb_data;
          end
        end
      endcase
    end
  end

endmodule
